// File: rtl/fdtd_hy_update_ctrl.sv
// -----------------------------------------------------------------------------
// fdtd_hy_update_ctrl
//
// Sequencer for one Hy field update pass. On an accepted start it streams Ez
// and Hy words from the field RAMs in ascending cell order into the Hy calc
// stage (which sits directly downstream). Each issued slot carries a
// (valid, addr) tag through a shift register that is matched to the calc
// stage latency. When a valid tag leaves that register, the calc result is
// written back to the Hy RAM. done pulses once the last write has retired.
//
// Optional feature macro: FDTD_HY_PMC_EN
//   When defined, the write for cell N-1 carries zero data. This models a
//   perfect magnetic conductor boundary. Address and timing are unchanged.
//
// Ports
//   CLK, RST_N              clock (rising edge), async active-low reset
//   start, n_cells          pass request and cell count N (latched on accept)
//   busy, done              pass in progress / one-cycle end-of-pass pulse
//   ez_rd_en/addr/data      Ez RAM read port (1-cycle synchronous latency)
//   hy_rd_en/addr/data      Hy RAM read port (1-cycle synchronous latency)
//   clken                   clock enable to the calc stage
//   Ez_old_o, Hy_old_o      operand pair presented to the calc stage
//   Hy_n_i                  registered result from the calc stage
//   hy_wr_en/addr/data      Hy RAM write port
// -----------------------------------------------------------------------------
module fdtd_hy_update_ctrl #(
    parameter int FDTD_DATA_WIDTH = 32,
    parameter int ADDR_W          = 10,
    parameter int CALC_LATENCY    = 6
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              start,
    input  logic        [ADDR_W-1:0]          n_cells,
    output logic                              busy,
    output logic                              done,
    output logic                              ez_rd_en,
    output logic        [ADDR_W-1:0]          ez_rd_addr,
    input  logic        [FDTD_DATA_WIDTH-1:0] ez_rd_data,
    output logic                              hy_rd_en,
    output logic        [ADDR_W-1:0]          hy_rd_addr,
    input  logic        [FDTD_DATA_WIDTH-1:0] hy_rd_data,
    output logic                              clken,
    output logic signed [FDTD_DATA_WIDTH-1:0] Ez_old_o,
    output logic signed [FDTD_DATA_WIDTH-1:0] Hy_old_o,
    input  logic signed [FDTD_DATA_WIDTH-1:0] Hy_n_i,
    output logic                              hy_wr_en,
    output logic        [ADDR_W-1:0]          hy_wr_addr,
    output logic        [FDTD_DATA_WIDTH-1:0] hy_wr_data
);

    // Tag depth counts the issue slot itself (stage 0, combinational), the
    // operand stage (stage 1) and CALC_LATENCY calc stages. Only stages
    // 1..TAG_DEPTH-1 are registers. A tag issued in cycle t therefore exits
    // in cycle t+1+CALC_LATENCY, aligned with its calc result.
    localparam int TAG_DEPTH = CALC_LATENCY + 2;
    localparam int TAG_LAST  = TAG_DEPTH - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]          n_q;

    // Set in the cycle after a read was issued: RAM data is valid now.
    logic                       rd_issued_q;
    logic                       prime_q;
    logic [FDTD_DATA_WIDTH-1:0] ez_hold_q;
    logic [FDTD_DATA_WIDTH-1:0] hy_hold_q;

    logic                       slot_valid;
    logic [ADDR_W-1:0]          slot_addr;
    logic [TAG_LAST:1]          tag_valid_q;
    logic [ADDR_W-1:0]          tag_addr_q [1:TAG_LAST];
    logic                       tags_pending;

    // Any valid tag still upstream of the exit stage. A tag sitting in the
    // exit stage is being written this cycle, so it does not hold DRAIN.
    always_comb begin
        tags_pending = 1'b0;
        for (int k = 1; k < TAG_LAST; k++) begin
            tags_pending = tags_pending | tag_valid_q[k];
        end
    end

    // Next-state and read-side outputs.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no
        // path can leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        ez_rd_en   = 1'b0;
        ez_rd_addr = '0;
        hy_rd_en   = 1'b0;
        hy_rd_addr = '0;
        slot_valid = 1'b0;
        slot_addr  = '0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = (n_cells == '0) ? S_FINISH : S_PRIME;
                end
            end
            S_PRIME: begin
                // Only loads the calc stage's Ez history; no Hy read, no tag.
                ez_rd_en = 1'b1;
                state_d  = S_STREAM;
            end
            S_STREAM: begin
                ez_rd_en   = 1'b1;
                ez_rd_addr = cnt_q + ADDR_W'(1);
                hy_rd_en   = 1'b1;
                hy_rd_addr = cnt_q;
                slot_valid = 1'b1;
                slot_addr  = cnt_q;
                if (cnt_q == n_q - ADDR_W'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (!tags_pending) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, operand holds and tag pipeline.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            rd_issued_q <= 1'b0;
            prime_q     <= 1'b0;
            ez_hold_q   <= '0;
            hy_hold_q   <= '0;
            tag_valid_q <= '0;
            // NOTE: the tag address array is small and is cleared on reset
            // like every other register, so writes never leave with stale
            // addresses after a mid-pass reset.
            for (int k = 1; k <= TAG_LAST; k++) begin
                tag_addr_q[k] <= '0;
            end
        end else begin
            // NOTE: all sequential state uses non-blocking assignments. Every
            // register then samples pre-edge values, and the shift register
            // below moves exactly one stage per clock.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_issued_q <= ez_rd_en;
            prime_q     <= (state_q == S_PRIME);
            if (state_q == S_IDLE && start) begin
                n_q <= n_cells;
            end
            if (rd_issued_q) begin
                ez_hold_q <= ez_rd_data;
                hy_hold_q <= prime_q ? '0 : hy_rd_data;
            end
            tag_valid_q[1] <= slot_valid;
            tag_addr_q[1]  <= slot_addr;
            for (int k = 2; k <= TAG_LAST; k++) begin
                tag_valid_q[k] <= tag_valid_q[k-1];
                tag_addr_q[k]  <= tag_addr_q[k-1];
            end
        end
    end

    // Operands follow RAM data in the cycle after the read. Otherwise they
    // hold the last loaded pair.
    assign Ez_old_o = rd_issued_q ? ez_rd_data : ez_hold_q;
    assign Hy_old_o = rd_issued_q ? (prime_q ? '0 : hy_rd_data) : hy_hold_q;

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_FINISH);
    assign clken = (state_q == S_PRIME) || (state_q == S_STREAM) || (state_q == S_DRAIN);

    // The calc output is already registered, so write data passes straight
    // through. It is gated to zero when no write is active.
    assign hy_wr_en   = tag_valid_q[TAG_LAST];
    assign hy_wr_addr = tag_valid_q[TAG_LAST] ? tag_addr_q[TAG_LAST] : '0;
`ifdef FDTD_HY_PMC_EN
    assign hy_wr_data = (!tag_valid_q[TAG_LAST]) ? '0 :
                        (tag_addr_q[TAG_LAST] == n_q - ADDR_W'(1)) ? '0 : Hy_n_i;
`else
    assign hy_wr_data = tag_valid_q[TAG_LAST] ? Hy_n_i : '0;
`endif

endmodule

// File: tb/tb_fdtd_hy_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fdtd_hy_update_ctrl
//
// Environment: Ez/Hy RAM models with 1-cycle synchronous reads, and a calc
// stage model with latency 6 computing Hy_n = Hy + (Ez_cur - Ez_prev).
// Expected per-cycle behaviour is derived from the pass timeline relative to
// start (cycle 0): read addresses, enables, operands, write cycles/data, done.
// -----------------------------------------------------------------------------
module tb_fdtd_hy_update_ctrl;
    localparam int W  = 32;
    localparam int AW = 10;
    localparam int L  = 6;
    localparam int NONE = 100000;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          start;
    logic [AW-1:0] n_cells;
    logic          busy, done;
    logic          ez_rd_en, hy_rd_en;
    logic [AW-1:0] ez_rd_addr, hy_rd_addr;
    logic [W-1:0]  ez_rd_data, hy_rd_data;
    logic          clken;
    logic [W-1:0]  Ez_old_o, Hy_old_o, Hy_n_i;
    logic          hy_wr_en;
    logic [AW-1:0] hy_wr_addr;
    logic [W-1:0]  hy_wr_data;

    always #5 CLK = ~CLK;

    fdtd_hy_update_ctrl #(
        .FDTD_DATA_WIDTH (W),
        .ADDR_W          (AW),
        .CALC_LATENCY    (L)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .n_cells    (n_cells),
        .busy       (busy),
        .done       (done),
        .ez_rd_en   (ez_rd_en),
        .ez_rd_addr (ez_rd_addr),
        .ez_rd_data (ez_rd_data),
        .hy_rd_en   (hy_rd_en),
        .hy_rd_addr (hy_rd_addr),
        .hy_rd_data (hy_rd_data),
        .clken      (clken),
        .Ez_old_o   (Ez_old_o),
        .Hy_old_o   (Hy_old_o),
        .Hy_n_i     (Hy_n_i),
        .hy_wr_en   (hy_wr_en),
        .hy_wr_addr (hy_wr_addr),
        .hy_wr_data (hy_wr_data)
    );

    // ---------------- RAM models ----------------
    logic [W-1:0] ez_mem [0:63];
    logic [W-1:0] hy_mem [0:63];

    always @(posedge CLK) begin
        if (ez_rd_en) ez_rd_data <= ez_mem[ez_rd_addr[5:0]];
        if (hy_rd_en) hy_rd_data <= hy_mem[hy_rd_addr[5:0]];
        if (hy_wr_en) hy_mem[hy_wr_addr[5:0]] <= hy_wr_data;
    end

    // ---------------- calc stage model ----------------
    logic [W-1:0] ez_hist;
    logic [W-1:0] calc_pipe [1:L];

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ez_hist <= '0;
            for (int k = 1; k <= L; k++) calc_pipe[k] <= '0;
        end else begin
            if (clken) ez_hist <= Ez_old_o;
            calc_pipe[1] <= Hy_old_o + (Ez_old_o - ez_hist);
            for (int k = 2; k <= L; k++) calc_pipe[k] <= calc_pipe[k-1];
        end
    end
    assign Hy_n_i = calc_pipe[L];

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pass: start is driven in cycle 0. Optionally a second start is
    // driven in cycle restart_c, and RST_N is pulled low in cycle rst_c.
    task automatic run_pass(input int n, input int restart_c, input int rst_c);
        logic [W-1:0] ez_ref [0:63];
        logic [W-1:0] hy_ref [0:63];
        logic         live, ez_e, hy_e, wr_e, op_e;
        logic [W-1:0] d;
        int           j;
        for (int i = 0; i < 64; i++) begin
            ez_ref[i] = ez_mem[i];
            hy_ref[i] = hy_mem[i];
        end
        @(negedge CLK);
        start   = 1'b1;
        n_cells = AW'(n);
        for (int c = 1; c <= n + L + 6; c++) begin
            @(negedge CLK);
            start   = (c == restart_c);
            n_cells = AW'($urandom_range(1, 30));
            if (c == rst_c) begin
                RST_N = 1'b0;
                #1;
            end
            if (c == rst_c + 2) RST_N = 1'b1;

            live = (c < rst_c);
            ez_e = live && n > 0 && c <= n + 1;
            hy_e = live && n > 0 && c >= 2 && c <= n + 1;
            j    = c - 3 - L;
            wr_e = live && n > 0 && j >= 0 && j < n;
            op_e = live && n > 0 && c >= 2 && c <= n + 2;

            check($sformatf("busy@%0d", c), 64'(busy),
                  64'(live && (n > 0 ? c <= n + 3 + L : c == 1)));
            check($sformatf("done@%0d", c), 64'(done),
                  64'(live && (n > 0 ? c == n + 3 + L : c == 1)));
            check($sformatf("clken@%0d", c), 64'(clken),
                  64'(live && n > 0 && c <= n + 2 + L));
            check($sformatf("ez_rd_en@%0d", c), 64'(ez_rd_en), 64'(ez_e));
            check($sformatf("hy_rd_en@%0d", c), 64'(hy_rd_en), 64'(hy_e));
            check($sformatf("hy_wr_en@%0d", c), 64'(hy_wr_en), 64'(wr_e));
            if (ez_e) check($sformatf("ez_rd_addr@%0d", c), 64'(ez_rd_addr), 64'(c - 1));
            if (hy_e) check($sformatf("hy_rd_addr@%0d", c), 64'(hy_rd_addr), 64'(c - 2));
            if (op_e) begin
                check($sformatf("Ez_old_o@%0d", c), 64'(Ez_old_o), 64'(ez_ref[c-2]));
                check($sformatf("Hy_old_o@%0d", c), 64'(Hy_old_o),
                      64'((c == 2) ? '0 : hy_ref[c-3]));
            end
            if (!live) begin
                check($sformatf("Ez_old_o_rst@%0d", c), 64'(Ez_old_o), 64'(0));
                check($sformatf("hy_wr_data_rst@%0d", c), 64'(hy_wr_data), 64'(0));
            end
            if (wr_e) begin
                d = hy_ref[j] + ez_ref[j+1] - ez_ref[j];
`ifdef FDTD_HY_PMC_EN
                if (j == n - 1) d = '0;
`endif
                check($sformatf("hy_wr_addr@%0d", c), 64'(hy_wr_addr), 64'(j));
                check($sformatf("hy_wr_data@%0d", c), 64'(hy_wr_data), 64'(d));
            end
        end
        start = 1'b0;
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            ez_mem[i] = $urandom;
            hy_mem[i] = $urandom;
        end
    endtask

    initial begin
        RST_N   = 1'b0;
        start   = 1'b0;
        n_cells = '0;
        for (int i = 0; i < 64; i++) begin
            ez_mem[i] = '0;
            hy_mem[i] = '0;
        end
        ez_mem[1] = 1;
        ez_mem[2] = 3;
        ez_mem[3] = 6;
        ez_mem[4] = 10;

        repeat (3) @(negedge CLK);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_clken", 64'(clken), 64'(0));
        check("rst_ez_rd_en", 64'(ez_rd_en), 64'(0));
        check("rst_hy_rd_en", 64'(hy_rd_en), 64'(0));
        check("rst_hy_wr_en", 64'(hy_wr_en), 64'(0));
        check("rst_Ez_old_o", 64'(Ez_old_o), 64'(0));
        check("rst_Hy_old_o", 64'(Hy_old_o), 64'(0));
        check("rst_hy_wr_data", 64'(hy_wr_data), 64'(0));
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Directed pass: writes 1,2,3,4 at cycles 9..12, done at 13.
        run_pass(4, 0, NONE);
        check("ram_hy0", 64'(hy_mem[0]), 64'(1));
        check("ram_hy2", 64'(hy_mem[2]), 64'(3));

        // Empty pass.
        run_pass(0, 0, NONE);

        // Restart while busy is ignored.
        fill_random();
        run_pass(4, 5, NONE);

        // Reset mid-pass, then a clean pass.
        fill_random();
        run_pass(4, 0, 7);
        run_pass(4, 0, NONE);

        // Single-cell boundary.
        fill_random();
        run_pass(1, 0, NONE);

        // Randomized passes.
        for (int p = 0; p < 5; p++) begin
            fill_random();
            run_pass($urandom_range(1, 24), 0, NONE);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
